half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 66 ++++++
 tb/tb_half_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// ----------------------------------------------------------------------------
// half_adder
//
// Purpose:
//   WIDTH independent single-bit half adders with no carry between lanes.
//   Each lane has a combinational sum/carry and a registered copy of both.
//   A saturating counter records how many clock edges saw a carry on at
//   least one lane.
//
// Parameters:
//   WIDTH  - number of independent bit-lanes (1..64)
//   CNT_W  - width of the carry-event counter (1..32)
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   a         in   WIDTH  addend A, one bit per lane
//   b         in   WIDTH  addend B, one bit per lane
//   sum       out  WIDTH  combinational a ^ b per lane
//   carry     out  WIDTH  combinational a & b per lane
//   sum_q     out  WIDTH  sum registered on the rising edge
//   carry_q   out  WIDTH  carry registered on the rising edge
//   carry_cnt out  CNT_W  saturating count of edges with any carry set
// ----------------------------------------------------------------------------
module half_adder #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic [CNT_W-1:0] carry_cnt
);

    // Combinational path: independent of clk and rst.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

    // Registered copies of the combinational outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end

    // Carry-event counter; stops at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if ((|carry) && (carry_cnt != '1)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// ----------------------------------------------------------------------------
// tb_half_adder
//
// Self-checking bench for half_adder. Three instances share clk/rst:
//   u1 : WIDTH=1, CNT_W=8
//   u4 : WIDTH=4, CNT_W=8
//   u3 : WIDTH=3, CNT_W=2 (exercises counter saturation)
// Combinational outputs are checked right after each input change; the
// registered response for the next edge is pushed into a queue and a
// monitor pops and compares it just after each rising edge.
// ----------------------------------------------------------------------------
module tb_half_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    logic [0:0] a1, b1, s1, c1, sq1, cq1;
    logic [7:0] n1;
    logic [3:0] a4, b4, s4, c4, sq4, cq4;
    logic [7:0] n4;
    logic [2:0] a3, b3, s3, c3, sq3, cq3;
    logic [1:0] n3;

    half_adder #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(s1), .carry(c1),
        .sum_q(sq1), .carry_q(cq1), .carry_cnt(n1)
    );
    half_adder #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .sum(s4), .carry(c4),
        .sum_q(sq4), .carry_q(cq4), .carry_cnt(n4)
    );
    half_adder #(.WIDTH(3), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .a(a3), .b(b3), .sum(s3), .carry(c3),
        .sum_q(sq3), .carry_q(cq3), .carry_cnt(n3)
    );

    typedef struct {
        logic [0:0] sq1, cq1;
        logic [7:0] n1;
        logic [3:0] sq4, cq4;
        logic [7:0] n4;
        logic [2:0] sq3, cq3;
        logic [1:0] n3;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    int          errors = 0;
    int          checks = 0;
    int unsigned m1 = 0, m4 = 0, m3 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each lane is a 1-bit arithmetic addition; the two result
    // bits are the low digit (sum) and the overflow digit (carry).
    function automatic void ha_ref(input logic [3:0] a, input logic [3:0] b, input int w,
                                   output logic [3:0] s, output logic [3:0] c);
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(a[i]) + int'(b[i]);
            s[i] = ((t % 2) == 1);
            c[i] = (t >= 2);
        end
    endfunction

    function automatic int unsigned bump(input int unsigned m, input bit hit, input int unsigned maxv);
        int unsigned n;
        n = m + (hit ? 1 : 0);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.sq1 = '0; e.cq1 = '0; e.n1 = '0;
        e.sq4 = '0; e.cq4 = '0; e.n4 = '0;
        e.sq3 = '0; e.cq3 = '0; e.n3 = '0;
        return e;
    endfunction

    // Drive new inputs, then check combinational outputs and that the
    // registered outputs have not moved without a clock edge.
    task automatic apply(input logic [0:0] na1, input logic [0:0] nb1,
                         input logic [3:0] na4, input logic [3:0] nb4,
                         input logic [2:0] na3, input logic [2:0] nb3);
        logic [3:0] es, ec;
        a1 = na1; b1 = nb1; a4 = na4; b4 = nb4; a3 = na3; b3 = nb3;
        #1;
        ha_ref({3'b0, na1}, {3'b0, nb1}, 1, es, ec);
        chk("sum1", 64'(s1), 64'(es[0])); chk("carry1", 64'(c1), 64'(ec[0]));
        ha_ref(na4, nb4, 4, es, ec);
        chk("sum4", 64'(s4), 64'(es)); chk("carry4", 64'(c4), 64'(ec));
        ha_ref({1'b0, na3}, {1'b0, nb3}, 3, es, ec);
        chk("sum3", 64'(s3), 64'(es[2:0])); chk("carry3", 64'(c3), 64'(ec[2:0]));
        chk("hold_sq1", 64'(sq1), 64'(last.sq1)); chk("hold_cq1", 64'(cq1), 64'(last.cq1));
        chk("hold_cnt1", 64'(n1), 64'(last.n1));
        chk("hold_sq4", 64'(sq4), 64'(last.sq4)); chk("hold_cnt3", 64'(n3), 64'(last.n3));
    endtask

    // Predict the registered state after the coming rising edge.
    task automatic push_edge();
        exp_t e;
        logic [3:0] s, c;
        if (rst) begin
            m1 = 0; m4 = 0; m3 = 0;
            e = zero_exp();
        end else begin
            ha_ref({3'b0, a1}, {3'b0, b1}, 1, s, c);
            e.sq1 = s[0]; e.cq1 = c[0];
            m1 = bump(m1, c != 0, 255); e.n1 = 8'(m1);
            ha_ref(a4, b4, 4, s, c);
            e.sq4 = s; e.cq4 = c;
            m4 = bump(m4, c != 0, 255); e.n4 = 8'(m4);
            ha_ref({1'b0, a3}, {1'b0, b3}, 3, s, c);
            e.sq3 = s[2:0]; e.cq3 = c[2:0];
            m3 = bump(m3, c != 0, 3); e.n3 = 2'(m3);
        end
        q.push_back(e);
        last = e;
    endtask

    task automatic cycle(input logic [0:0] na1, input logic [0:0] nb1,
                         input logic [3:0] na4, input logic [3:0] nb4,
                         input logic [2:0] na3, input logic [2:0] nb3);
        @(negedge clk);
        apply(na1, nb1, na4, nb4, na3, nb3);
        push_edge();
    endtask

    task automatic rand_cycle();
        cycle(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              3'($urandom), 3'($urandom));
    endtask

    task automatic check_regs_zero(input string tag);
        chk({tag, "_sq1"}, 64'(sq1), 64'd0); chk({tag, "_cq1"}, 64'(cq1), 64'd0);
        chk({tag, "_cnt1"}, 64'(n1), 64'd0);
        chk({tag, "_sq4"}, 64'(sq4), 64'd0); chk({tag, "_cq4"}, 64'(cq4), 64'd0);
        chk({tag, "_cnt4"}, 64'(n4), 64'd0);
        chk({tag, "_sq3"}, 64'(sq3), 64'd0); chk({tag, "_cq3"}, 64'(cq3), 64'd0);
        chk({tag, "_cnt3"}, 64'(n3), 64'd0);
    endtask

    // Assert reset between edges and confirm it takes effect immediately.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_regs_zero("async_rst");
        m1 = 0; m4 = 0; m3 = 0;
        last = zero_exp();
        apply(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              3'($urandom), 3'($urandom));
        push_edge();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 1'b1, 4'b1100, 4'b1010, 3'b111, 3'b010);
        push_edge();
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sum_q1", 64'(sq1), 64'(e.sq1)); chk("carry_q1", 64'(cq1), 64'(e.cq1));
            chk("cnt1", 64'(n1), 64'(e.n1));
            chk("sum_q4", 64'(sq4), 64'(e.sq4)); chk("carry_q4", 64'(cq4), 64'(e.cq4));
            chk("cnt4", 64'(n4), 64'(e.n4));
            chk("sum_q3", 64'(sq3), 64'(e.sq3)); chk("carry_q3", 64'(cq3), 64'(e.cq3));
            chk("cnt3", 64'(n3), 64'(e.n3));
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [0:0] wa[4], wb[4], ws[4], wc[4];
        wa = '{1'b1, 1'b0, 1'b0, 1'b1};
        wb = '{1'b1, 1'b1, 1'b0, 1'b0};
        ws = '{1'b0, 1'b1, 1'b0, 1'b1};
        wc = '{1'b1, 1'b0, 1'b0, 1'b0};

        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a3 = '0; b3 = '0;
        last = zero_exp();
        #1 rst = 1'b1;
        #2;
        check_regs_zero("reset");

        // Clock edges during reset leave state at zero; comb keeps tracking.
        rand_cycle();
        rand_cycle();
        release_reset();

        // Truth-table walk, 2 time units per step, checked right after each change.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            apply(wa[i], wb[i], 4'b1100, 4'b1010, 3'b000, 3'b000);
            chk("walk_sum", 64'(s1), 64'(ws[i]));
            chk("walk_carry", 64'(c1), 64'(wc[i]));
            #1;
        end
        push_edge();

        // Restart counting from zero for the directed counter checks.
        async_reset();
        release_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'b1100, 4'b1010, 3'b111, 3'b011);
        @(negedge clk);
        chk("cnt1_after5", 64'(n1), 64'd5);
        chk("cnt4_after5", 64'(n4), 64'd5);
        chk("cnt3_sat", 64'(n3), 64'd3);
        chk("sum4_dir", 64'(s4), 64'b0110);
        chk("carry4_dir", 64'(c4), 64'b1000);
        apply(1'b1, 1'b0, 4'b0101, 4'b1010, 3'b111, 3'b001);
        push_edge();
        cycle(1'b1, 1'b0, 4'b0101, 4'b1010, 3'b111, 3'b001);
        cycle(1'b1, 1'b0, 4'b0101, 4'b1010, 3'b111, 3'b001);
        @(negedge clk);
        chk("cnt1_hold", 64'(n1), 64'd5);
        chk("cnt4_hold", 64'(n4), 64'd5);
        chk("cnt3_stay_sat", 64'(n3), 64'd3);

        // Async reset with the counter at 5.
        async_reset();
        rand_cycle();
        release_reset();

        // Drive the 8-bit counters into saturation, then reset while saturated.
        for (int i = 0; i < 260; i++) cycle(1'b1, 1'b1, 4'($urandom) | 4'b0001, 4'b1111, 3'b111, 3'b111);
        @(negedge clk);
        chk("cnt1_sat", 64'(n1), 64'd255);
        chk("cnt4_sat", 64'(n4), 64'd255);
        async_reset();
        release_reset();

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
                release_reset();
            end else begin
                rand_cycle();
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
